// File: rtl/argmax_selector_pkg.sv
// Shared state encoding and sizing constants for the argmax selector.
package argmax_selector_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int unsigned IDX_W               = 4;
  localparam int unsigned DEFAULT_SCORE_WIDTH = 16;
  localparam int unsigned DEFAULT_NUM_CLASSES = 10;
endpackage

// File: rtl/argmax_selector_if.sv
// Score stream and result bus of the argmax selector.
// ARGMAX_RUNNER_UP_EN adds runner_index and margin to the result side.
interface argmax_selector_if
  import argmax_selector_pkg::*;
#(
  parameter int unsigned SCORE_WIDTH = DEFAULT_SCORE_WIDTH
) ();
  logic                   start;
  logic                   score_valid;
  logic [SCORE_WIDTH-1:0] score_data;
  logic                   score_ready;
  logic                   busy;
  logic                   result_valid;
  logic [IDX_W-1:0]       result_index;
  logic [SCORE_WIDTH-1:0] result_score;
`ifdef ARGMAX_RUNNER_UP_EN
  logic [IDX_W-1:0]       runner_index;
  logic [SCORE_WIDTH-1:0] margin;

  modport master (
    output start, score_valid, score_data,
    input  score_ready, busy, result_valid, result_index, result_score,
    input  runner_index, margin
  );
  modport slave (
    input  start, score_valid, score_data,
    output score_ready, busy, result_valid, result_index, result_score,
    output runner_index, margin
  );
`else
  modport master (
    output start, score_valid, score_data,
    input  score_ready, busy, result_valid, result_index, result_score
  );
  modport slave (
    input  start, score_valid, score_data,
    output score_ready, busy, result_valid, result_index, result_score
  );
`endif
endinterface

// File: rtl/argmax_selector_score_compare.sv
// Combinational magnitude comparator, signed or unsigned by parameter.
module score_compare #(
  parameter int unsigned SCORE_WIDTH    = 16,
  parameter bit          TwosComplement = 1'b1
) (
  input  logic [SCORE_WIDTH-1:0] a,
  input  logic [SCORE_WIDTH-1:0] b,
  output logic                   gt,
  output logic                   eq,
  output logic                   lt
);
  always_comb begin
    eq = (a == b);
    if (TwosComplement) begin
      gt = ($signed(a) > $signed(b));
      lt = ($signed(a) < $signed(b));
    end else begin
      gt = (a > b);
      lt = (a < b);
    end
  end
endmodule

// File: rtl/argmax_selector.sv
// Streaming argmax over NUM_CLASSES scores with one shared comparator.
// ARGMAX_RUNNER_UP_EN adds runner-up index and saturated margin outputs.
module argmax_selector
  import argmax_selector_pkg::*;
#(
  parameter int unsigned SCORE_WIDTH    = DEFAULT_SCORE_WIDTH,
  parameter int unsigned NUM_CLASSES    = DEFAULT_NUM_CLASSES,
  parameter bit          TwosComplement = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  argmax_selector_if.slave  bus
);
  state_t                 state;
  logic [IDX_W-1:0]       count;
  logic [SCORE_WIDTH-1:0] run_max;
  logic [IDX_W-1:0]       run_idx;
  logic [SCORE_WIDTH-1:0] nxt_max;
  logic [IDX_W-1:0]       nxt_idx;
  logic                   accept;
  logic                   last;
  logic                   gt_max;
  logic                   eq_max;
  logic                   lt_max;
  logic                   unused_cmp;

  assign accept     = bus.score_valid & bus.score_ready;
  assign last       = (count == IDX_W'(NUM_CLASSES - 1));
  assign unused_cmp = ^{lt_max, eq_max};

  score_compare #(.SCORE_WIDTH(SCORE_WIDTH), .TwosComplement(TwosComplement)) u_cmp_max (
    .a(bus.score_data), .b(run_max), .gt(gt_max), .eq(eq_max), .lt(lt_max)
  );

  // Strict greater-than keeps the lower index on ties.
  always_comb begin
    nxt_max = run_max;
    nxt_idx = run_idx;
    if (count == '0 || gt_max) begin
      nxt_max = bus.score_data;
      nxt_idx = count;
    end
  end

`ifdef ARGMAX_RUNNER_UP_EN
  logic [SCORE_WIDTH-1:0] run_ru;
  logic [IDX_W-1:0]       run_ru_idx;
  logic                   ru_ok;
  logic [SCORE_WIDTH-1:0] nxt_ru;
  logic [IDX_W-1:0]       nxt_ru_idx;
  logic                   nxt_ru_ok;
  logic                   gt_ru;
  logic                   eq_ru;
  logic                   lt_ru;
  logic                   unused_ru;
  logic [SCORE_WIDTH:0]   diff;
  logic [SCORE_WIDTH-1:0] nxt_margin;

  assign unused_ru = ^{eq_ru, lt_ru};

  score_compare #(.SCORE_WIDTH(SCORE_WIDTH), .TwosComplement(TwosComplement)) u_cmp_ru (
    .a(bus.score_data), .b(run_ru), .gt(gt_ru), .eq(eq_ru), .lt(lt_ru)
  );

  // Scores equal to the running max are skipped so the runner-up stays
  // strictly below the winner; ru_ok marks whether one has been seen yet.
  always_comb begin
    nxt_ru     = run_ru;
    nxt_ru_idx = run_ru_idx;
    nxt_ru_ok  = ru_ok;
    if (count == '0) begin
      nxt_ru     = bus.score_data;
      nxt_ru_idx = '0;
      nxt_ru_ok  = 1'b0;
    end else if (gt_max) begin
      nxt_ru     = run_max;
      nxt_ru_idx = run_idx;
      nxt_ru_ok  = 1'b1;
    end else if (!eq_max && (!ru_ok || gt_ru)) begin
      nxt_ru     = bus.score_data;
      nxt_ru_idx = count;
      nxt_ru_ok  = 1'b1;
    end
  end

  always_comb begin
    if (TwosComplement)
      diff = {nxt_max[SCORE_WIDTH-1], nxt_max} - {nxt_ru[SCORE_WIDTH-1], nxt_ru};
    else
      diff = {1'b0, nxt_max} - {1'b0, nxt_ru};
    nxt_margin = diff[SCORE_WIDTH] ? '1 : diff[SCORE_WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      count            <= '0;
      run_max          <= '0;
      run_idx          <= '0;
      bus.score_ready  <= 1'b0;
      bus.busy         <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.result_index <= '0;
      bus.result_score <= '0;
`ifdef ARGMAX_RUNNER_UP_EN
      run_ru           <= '0;
      run_ru_idx       <= '0;
      ru_ok            <= 1'b0;
      bus.runner_index <= '0;
      bus.margin       <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state            <= COLLECT;
            count            <= '0;
            bus.score_ready  <= 1'b1;
            bus.busy         <= 1'b1;
            bus.result_valid <= 1'b0;
          end
        end
        COLLECT: begin
          if (accept) begin
            run_max <= nxt_max;
            run_idx <= nxt_idx;
            count   <= count + 1'b1;
`ifdef ARGMAX_RUNNER_UP_EN
            run_ru     <= nxt_ru;
            run_ru_idx <= nxt_ru_idx;
            ru_ok      <= nxt_ru_ok;
`endif
            if (last) begin
              state            <= DONE;
              bus.score_ready  <= 1'b0;
              bus.busy         <= 1'b0;
              bus.result_valid <= 1'b1;
              bus.result_index <= nxt_idx;
              bus.result_score <= nxt_max;
`ifdef ARGMAX_RUNNER_UP_EN
              bus.runner_index <= nxt_ru_idx;
              bus.margin       <= nxt_margin;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
